// File: rtl/tl_c_pkg.sv
// TileLink channel C/D definitions shared by the manager-side release sink.
package tl_c_pkg;

  localparam logic [2:0] OP_PROBE_ACK        = 3'd4;
  localparam logic [2:0] OP_PROBE_ACK_DATA   = 3'd5;
  localparam logic [2:0] OP_RELEASE          = 3'd6;
  localparam logic [2:0] OP_RELEASE_DATA     = 3'd7;
  localparam logic [2:0] OP_RELEASE_ACK      = 3'd6;

  // Header field widths; release_sink defaults its parameters to these.
  localparam int unsigned HDR_ADDR_W   = 32;
  localparam int unsigned HDR_SOURCE_W = 4;

  typedef enum logic [1:0] {
    s_idle,
    s_collect,
    s_write,
    s_ack
  } state_e;

  typedef struct packed {
    logic [2:0]              opcode;
    logic [2:0]              param;
    logic [3:0]              size;
    logic [HDR_SOURCE_W-1:0] source;
    logic [HDR_ADDR_W-1:0]   address;
  } c_hdr_t;

  function automatic logic isData(input logic [2:0] opcode);
    return (opcode == OP_PROBE_ACK_DATA) || (opcode == OP_RELEASE_DATA);
  endfunction

endpackage

// File: rtl/release_line_buffer.sv
// One cache line of C-channel beats, written a beat at a time and read flat.
module release_line_buffer #(
  parameter int unsigned ROW_BITS      = 128,
  parameter int unsigned REFILL_CYCLES = 4,
  parameter int unsigned IDX_W         = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              we,
  input  logic [IDX_W-1:0]                  idx,
  input  logic [ROW_BITS-1:0]               wdata,
  output logic [ROW_BITS*REFILL_CYCLES-1:0] line
);

  logic [ROW_BITS-1:0] mem [REFILL_CYCLES];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < REFILL_CYCLES; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Beat 0 occupies the least significant row.
  always_comb begin
    line = '0;
    for (int unsigned i = 0; i < REFILL_CYCLES; i++) begin
      line[i*ROW_BITS +: ROW_BITS] = mem[i];
    end
  end

endmodule

// File: rtl/release_sink.sv
// Manager-side TileLink C sink: assembles ProbeAck/Release traffic into line
// writes, acks voluntary Releases on D and signals probe completion.
module release_sink
  import tl_c_pkg::*;
#(
  parameter int unsigned ROW_BITS       = 128,
  parameter int unsigned REFILL_CYCLES  = 4,
  parameter int unsigned ADDR_BITS      = HDR_ADDR_W,
  parameter int unsigned SOURCE_BITS    = HDR_SOURCE_W,
  parameter int unsigned BLOCK_OFF_BITS = 6
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              c_valid,
  output logic                              c_ready,
  input  logic [2:0]                        c_opcode,
  input  logic [2:0]                        c_param,
  input  logic [3:0]                        c_size,
  input  logic [SOURCE_BITS-1:0]            c_source,
  input  logic [ADDR_BITS-1:0]              c_address,
  input  logic [ROW_BITS-1:0]               c_data,
  output logic                              d_valid,
  input  logic                              d_ready,
  output logic [2:0]                        d_opcode,
  output logic [SOURCE_BITS-1:0]            d_source,
  output logic [3:0]                        d_size,
  output logic                              wr_valid,
  input  logic                              wr_ready,
  output logic [ADDR_BITS-1:0]              wr_addr,
  output logic [ROW_BITS*REFILL_CYCLES-1:0] wr_data,
  output logic                              wr_has_data,
  output logic [2:0]                        wr_param,
  output logic                              probe_done,
  output logic [2:0]                        probe_param,
  output logic                              err
);

  localparam int unsigned CNT_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(REFILL_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] OFF_MASK =
    {{(ADDR_BITS-BLOCK_OFF_BITS){1'b0}}, {BLOCK_OFF_BITS{1'b1}}};

  state_e                            state_q, state_d;
  c_hdr_t                            hdr_q;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              err_q, err_set;
  logic                              latch_hdr;
  logic                              buf_we;
  logic [CNT_W-1:0]                  buf_idx;
  logic [ROW_BITS*REFILL_CYCLES-1:0] line;
  logic                              ready_int, wr_v_int, d_v_int, pd_int;

  release_line_buffer #(
    .ROW_BITS      (ROW_BITS),
    .REFILL_CYCLES (REFILL_CYCLES),
    .IDX_W         (CNT_W)
  ) u_line_buffer (
    .clock (clock),
    .reset (reset),
    .we    (buf_we),
    .idx   (buf_idx),
    .wdata (c_data),
    .line  (line)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= s_idle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_int = 1'b0;
    wr_v_int  = 1'b0;
    d_v_int   = 1'b0;
    pd_int    = 1'b0;
    buf_we    = 1'b0;
    buf_idx   = cnt_q;
    latch_hdr = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      s_idle: begin
        ready_int = 1'b1;
        if (c_valid) begin
          if (!c_opcode[2]) begin
            // Opcodes 0..3 never belong on C at the manager: flag and drop.
            err_set = 1'b1;
          end else begin
            latch_hdr = 1'b1;
            if (isData(c_opcode)) begin
              buf_we  = 1'b1;
              buf_idx = '0;
              if (c_size != 4'(BLOCK_OFF_BITS)) err_set = 1'b1;
              if (REFILL_CYCLES > 1) begin
                cnt_d   = CNT_W'(1);
                state_d = s_collect;
              end else begin
                state_d = s_write;
              end
            end else begin
              state_d = s_write;
            end
          end
        end
      end
      s_collect: begin
        ready_int = 1'b1;
        if (c_valid) begin
          buf_we = 1'b1;
          if ((c_opcode != hdr_q.opcode) ||
              (c_source != hdr_q.source[SOURCE_BITS-1:0]) ||
              (c_address != hdr_q.address[ADDR_BITS-1:0])) begin
            err_set = 1'b1;
          end
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = s_write;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      s_write: begin
        wr_v_int = 1'b1;
        if (wr_ready) begin
          if (hdr_q.opcode[1]) begin
            state_d = s_ack;
          end else begin
            pd_int  = 1'b1;
            state_d = s_idle;
          end
        end
      end
      s_ack: begin
        d_v_int = 1'b1;
        if (d_ready) state_d = s_idle;
      end
      default: state_d = s_idle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hdr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (err_set) err_q <= 1'b1;
      if (latch_hdr) begin
        hdr_q.opcode  <= c_opcode;
        hdr_q.param   <= c_param;
        hdr_q.size    <= c_size;
        hdr_q.source  <= HDR_SOURCE_W'(c_source);
        hdr_q.address <= HDR_ADDR_W'(c_address);
      end
    end
  end

  // Every output is held at zero for as long as reset is asserted.
  always_comb begin
    c_ready     = 1'b0;
    d_valid     = 1'b0;
    d_opcode    = '0;
    d_source    = '0;
    d_size      = '0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    wr_has_data = 1'b0;
    wr_param    = '0;
    probe_done  = 1'b0;
    probe_param = '0;
    err         = 1'b0;
    if (!reset) begin
      c_ready     = ready_int;
      d_valid     = d_v_int;
      d_opcode    = d_v_int ? OP_RELEASE_ACK : 3'd0;
      d_source    = hdr_q.source[SOURCE_BITS-1:0];
      d_size      = hdr_q.size;
      wr_valid    = wr_v_int;
      wr_addr     = hdr_q.address[ADDR_BITS-1:0] & ~OFF_MASK;
      wr_data     = line;
      wr_has_data = isData(hdr_q.opcode);
      wr_param    = hdr_q.param;
      probe_done  = pd_int;
      probe_param = hdr_q.param;
      err         = err_q;
    end
  end

endmodule

// File: tb/tb_release_sink.sv
// Randomized bench for release_sink against a message-level reference model.
module tb_release_sink;

  localparam int RB = 128;
  localparam int RC = 4;
  localparam int AB = 32;
  localparam int SB = 4;
  localparam int BO = 6;

  logic            clock = 1'b0;
  logic            reset;
  logic            c_valid, c_ready;
  logic [2:0]      c_opcode, c_param;
  logic [3:0]      c_size;
  logic [SB-1:0]   c_source;
  logic [AB-1:0]   c_address;
  logic [RB-1:0]   c_data;
  logic            d_valid, d_ready;
  logic [2:0]      d_opcode;
  logic [SB-1:0]   d_source;
  logic [3:0]      d_size;
  logic            wr_valid, wr_ready;
  logic [AB-1:0]   wr_addr;
  logic [RB*RC-1:0] wr_data;
  logic            wr_has_data;
  logic [2:0]      wr_param;
  logic            probe_done;
  logic [2:0]      probe_param;
  logic            err;

  release_sink #(
    .ROW_BITS       (RB),
    .REFILL_CYCLES  (RC),
    .ADDR_BITS      (AB),
    .SOURCE_BITS    (SB),
    .BLOCK_OFF_BITS (BO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .c_valid     (c_valid),
    .c_ready     (c_ready),
    .c_opcode    (c_opcode),
    .c_param     (c_param),
    .c_size      (c_size),
    .c_source    (c_source),
    .c_address   (c_address),
    .c_data      (c_data),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_opcode    (d_opcode),
    .d_source    (d_source),
    .d_size      (d_size),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_has_data (wr_has_data),
    .wr_param    (wr_param),
    .probe_done  (probe_done),
    .probe_param (probe_param),
    .err         (err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit err_exp;

  // Current message as the upstream client intends it.
  logic [2:0]    m_op, m_param;
  logic [3:0]    m_size;
  logic [SB-1:0] m_src;
  logic [AB-1:0] m_addr;
  logic [RB-1:0] m_data [RC];
  int            m_bad_beat;
  int            m_bad_kind;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RB-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_junk(input bit v);
    c_valid   = v;
    c_opcode  = 3'($urandom_range(4, 7));
    c_param   = 3'($urandom);
    c_size    = 4'($urandom);
    c_source  = SB'($urandom);
    c_address = $urandom;
    c_data    = rand_row();
  endtask

  // Checks for a cycle in which the sink should be accepting C.
  task automatic chk_accepting();
    chk("c_ready_open", c_ready, 1'b1);
    chk("wr_valid_idle", wr_valid, 1'b0);
    chk("d_valid_idle", d_valid, 1'b0);
    chk("probe_done_idle", probe_done, 1'b0);
    chk("err", err, err_exp);
  endtask

  task automatic chk_all_zero();
    chk("rst_c_ready", c_ready, 1'b0);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_probe_done", probe_done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_d_opcode", d_opcode, 3'd0);
    chk("rst_wr_has_data", wr_has_data, 1'b0);
  endtask

  task automatic send_msg(input int pre_gap, input int max_gap, input int wr_stall,
                          input int d_stall, input bit cbusy);
    bit is_data, illegal, is_rel;
    int nbeats, gap;
    logic [RB*RC-1:0] exp_line;
    is_data = (m_op == 3'd5) || (m_op == 3'd7);
    illegal = (m_op < 3'd4);
    is_rel  = (m_op == 3'd6) || (m_op == 3'd7);
    nbeats  = is_data ? RC : 1;
    for (int b = 0; b < nbeats; b++) begin
      gap = (b == 0) ? pre_gap : ((max_gap > 0) ? $urandom_range(0, max_gap) : 0);
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        drive_junk(1'b0);
        wr_ready = 1'($urandom);
        d_ready  = 1'($urandom);
        #1 chk_accepting();
      end
      @(negedge clock);
      c_valid   = 1'b1;
      c_opcode  = m_op;
      c_param   = m_param;
      c_size    = m_size;
      c_source  = m_src;
      c_address = m_addr;
      c_data    = m_data[b];
      if (b > 0 && b == m_bad_beat) begin
        case (m_bad_kind)
          0:       c_source  = m_src ^ SB'(6);
          1:       c_opcode  = m_op ^ 3'b010;
          default: c_address = m_addr ^ 32'h100;
        endcase
      end
      wr_ready = 1'($urandom);
      d_ready  = 1'($urandom);
      #1 chk_accepting();
      if (illegal) err_exp = 1'b1;
      if (b == 0 && is_data && m_size != 4'(BO)) err_exp = 1'b1;
      if (b > 0 && b == m_bad_beat) err_exp = 1'b1;
    end
    if (illegal) return;

    for (int i = 0; i < RC; i++) exp_line[i*RB +: RB] = m_data[i];
    for (int k = 0; k <= wr_stall; k++) begin
      @(negedge clock);
      drive_junk(cbusy ? 1'b1 : 1'($urandom));
      wr_ready = (k == wr_stall);
      d_ready  = 1'($urandom);
      #1;
      chk("wr_valid", wr_valid, 1'b1);
      chk("c_ready_wr", c_ready, 1'b0);
      chk("d_valid_wr", d_valid, 1'b0);
      chk("err", err, err_exp);
      if (wr_ready) begin
        chk("wr_addr", wr_addr, (m_addr >> BO) << BO);
        chk("wr_has_data", wr_has_data, is_data);
        chk("wr_param", wr_param, m_param);
        if (is_data) chk("wr_data", wr_data, exp_line);
        chk("probe_done", probe_done, !is_rel);
        if (!is_rel) chk("probe_param", probe_param, m_param);
      end else begin
        chk("probe_done_stall", probe_done, 1'b0);
      end
    end

    if (!is_rel) return;
    for (int k = 0; k <= d_stall; k++) begin
      @(negedge clock);
      drive_junk(cbusy ? 1'b1 : 1'($urandom));
      d_ready  = (k == d_stall);
      wr_ready = 1'($urandom);
      #1;
      chk("d_valid", d_valid, 1'b1);
      chk("d_opcode", d_opcode, 3'd6);
      chk("d_source", d_source, m_src);
      chk("d_size", d_size, m_size);
      chk("c_ready_ack", c_ready, 1'b0);
      chk("wr_valid_ack", wr_valid, 1'b0);
      chk("probe_done_ack", probe_done, 1'b0);
    end
  endtask

  task automatic set_msg(input logic [2:0] op, input logic [2:0] prm, input logic [3:0] sz,
                         input logic [SB-1:0] src, input logic [AB-1:0] addr);
    m_op = op; m_param = prm; m_size = sz; m_src = src; m_addr = addr;
    for (int i = 0; i < RC; i++) m_data[i] = rand_row();
    m_bad_beat = -1;
    m_bad_kind = 0;
  endtask

  task automatic new_rand_msg();
    bit is_data;
    if ($urandom_range(0, 9) == 0) m_op = 3'($urandom_range(0, 3));
    else                           m_op = 3'($urandom_range(4, 7));
    is_data = (m_op == 3'd5) || (m_op == 3'd7);
    m_param = 3'($urandom);
    m_src   = SB'($urandom);
    m_addr  = $urandom;
    if (is_data) m_size = ($urandom_range(0, 7) == 0) ? 4'd5 : 4'd6;
    else         m_size = 4'($urandom);
    for (int i = 0; i < RC; i++) m_data[i] = rand_row();
    m_bad_beat = (is_data && $urandom_range(0, 5) == 0) ? $urandom_range(1, RC - 1) : -1;
    m_bad_kind = $urandom_range(0, 2);
  endtask

  // Two beats of a ReleaseData, then reset lands on the third.
  task automatic reset_mid_line();
    set_msg(3'd7, 3'd0, 4'd6, SB'(3), 32'h8000_0040);
    for (int b = 0; b < 2; b++) begin
      @(negedge clock);
      c_valid = 1'b1; c_opcode = m_op; c_param = m_param; c_size = m_size;
      c_source = m_src; c_address = m_addr; c_data = m_data[b];
      wr_ready = 1'b1; d_ready = 1'b1;
      #1 chk_accepting();
    end
    @(negedge clock);
    reset  = 1'b1;
    c_data = m_data[2];
    #1 chk_all_zero();
    err_exp = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    drive_junk(1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      drive_junk(1'b0);
      #1 chk_accepting();
    end
  endtask

  initial begin
    reset    = 1'b1;
    wr_ready = 1'b0;
    d_ready  = 1'b0;
    err_exp  = 1'b0;
    drive_junk(1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1 chk_all_zero();
    end
    @(negedge clock);
    reset = 1'b0;
    drive_junk(1'b0);

    // ReleaseData, no stalls: wr in the cycle after beat 3, ack the cycle after.
    set_msg(3'd7, 3'd0, 4'd6, SB'(3), 32'h8000_0040);
    m_data[0] = {4{32'h1111_1111}};
    m_data[1] = {4{32'h2222_2222}};
    m_data[2] = {4{32'h3333_3333}};
    m_data[3] = {4{32'h4444_4444}};
    send_msg(0, 0, 0, 0, 1'b0);

    // Dataless Release: address low bits cleared, no collect phase.
    set_msg(3'd6, 3'd1, 4'd6, SB'(2), 32'h1234_5678);
    send_msg(0, 0, 0, 0, 1'b0);

    // ProbeAckData with the backing store stalled for five cycles.
    set_msg(3'd5, 3'd2, 4'd6, SB'(7), 32'h0000_1f80);
    send_msg(1, 1, 5, 0, 1'b1);

    // Source changes on beat 2: sticky err, line still written and acked to 3.
    set_msg(3'd7, 3'd0, 4'd6, SB'(3), 32'h8000_0040);
    m_bad_beat = 2;
    m_bad_kind = 0;
    send_msg(0, 0, 0, 0, 1'b0);

    reset_mid_line();
    set_msg(3'd4, 3'd3, 4'd6, SB'(9), 32'h0000_0400);
    send_msg(0, 0, 0, 0, 1'b0);

    // Ack held for ten cycles with C pushing; next message goes straight in.
    set_msg(3'd6, 3'd4, 4'd6, SB'(12), 32'hdead_beef);
    send_msg(0, 0, 0, 10, 1'b1);
    set_msg(3'd4, 3'd5, 4'd6, SB'(1), 32'h0000_2000);
    send_msg(0, 0, 0, 0, 1'b0);

    reset_mid_line();
    for (int n = 0; n < 60; n++) begin
      new_rand_msg();
      send_msg($urandom_range(0, 2), 2, $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom));
    end

    @(negedge clock);
    drive_junk(1'b0);
    #1 chk_accepting();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
